// File: rtl/puf_pkg.sv
// Shared types for the arbiter PUF: controller state encoding and vote-count width helper.
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_LAUNCH,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } puf_state_e;

  function automatic int vote_width(input int n_votes);
    return $clog2(n_votes + 1);
  endfunction

endpackage

// File: rtl/puf_switch_stage.sv
// One crossing switch of the delay chain: straight when sel_i=0, crossed when sel_i=1.
module puf_switch_stage (
  input  logic sel_i,
  input  logic top_i,
  input  logic bot_i,
  output logic top_o,
  output logic bot_o
);

  (* keep = "true" *) logic top_mux;
  (* keep = "true" *) logic bot_mux;

  assign top_mux = sel_i ? bot_i : top_i;
  assign bot_mux = sel_i ? top_i : bot_i;
  assign top_o   = top_mux;
  assign bot_o   = bot_mux;

endmodule

// File: rtl/puf_arbiter_chain.sv
// Arbiter PUF: N_STAGES switch chain, first-arrival arbiter, N_VOTES majority vote.
// One challenge at a time; response held until resp_ready, no challenge queuing.
module puf_arbiter_chain
  import puf_pkg::*;
#(
  parameter int N_STAGES      = 64,
  parameter int SETTLE_CYCLES = 8,
  parameter int N_VOTES       = 5,
  parameter int VW            = vote_width(N_VOTES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chal_valid,
  output logic                chal_ready,
  input  logic [N_STAGES-1:0] chal,
  input  logic                test_mode,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp,
  output logic [VW-1:0]       resp_conf,
  output logic                busy
);

  localparam int            CW          = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(1);
  localparam logic [VW-1:0] VOTES_MAX   = VW'(N_VOTES);
  localparam logic [VW-1:0] VOTES_HALF  = VW'(N_VOTES / 2);

  if ((N_VOTES % 2) == 0 || N_STAGES < 1 || N_STAGES > 256 || SETTLE_CYCLES < 2) begin : g_bad_param
    $error("puf_arbiter_chain: illegal N_VOTES, N_STAGES or SETTLE_CYCLES");
  end

  puf_state_e          state_q;
  logic [CW-1:0]       cnt_q;
  logic [N_STAGES-1:0] chal_q;
  logic                tm_q;
  logic                launch_top_q, launch_bot_q;
  logic [VW-1:0]       ones_q, vote_q, ones_d, vote_d;
  logic                chal_ready_q, resp_valid_q, resp_q, busy_q;
  logic [VW-1:0]       resp_conf_q;
  logic                arb_q, arb_lock_q, sync1_q, sync2_q;
  logic                arb_clr;

  logic [N_STAGES:0] top_path, bot_path;
  assign top_path[0] = launch_top_q;
  assign bot_path[0] = launch_bot_q;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
    puf_switch_stage u_stage (
      .sel_i (chal_q[i]),
      .top_i (top_path[i]),
      .bot_i (bot_path[i]),
      .top_o (top_path[i+1]),
      .bot_o (bot_path[i+1])
    );
  end

  // Arbiter latches the first edge to arrive; a simultaneous arrival locks in the cleared 0.
  assign arb_clr = (state_q == ST_IDLE) || (state_q == ST_ARM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_q      <= 1'b0;
      arb_lock_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
    end else begin
      sync1_q <= arb_q;
      sync2_q <= sync1_q;
      if (arb_clr) begin
        arb_q      <= 1'b0;
        arb_lock_q <= 1'b0;
      end else if (!arb_lock_q && (top_path[N_STAGES] || bot_path[N_STAGES])) begin
        arb_lock_q <= 1'b1;
        arb_q      <= top_path[N_STAGES] & ~bot_path[N_STAGES];
      end
    end
  end

  assign ones_d = (sync2_q && ones_q != VOTES_MAX) ? ones_q + VW'(1) : ones_q;
  assign vote_d = (vote_q != VOTES_MAX) ? vote_q + VW'(1) : vote_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      chal_q       <= '0;
      tm_q         <= 1'b0;
      launch_top_q <= 1'b0;
      launch_bot_q <= 1'b0;
      ones_q       <= '0;
      vote_q       <= '0;
      chal_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_q       <= 1'b0;
      resp_conf_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          chal_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          if (chal_valid && chal_ready_q) begin
            chal_q       <= chal;
            tm_q         <= test_mode;
            ones_q       <= '0;
            vote_q       <= '0;
            cnt_q        <= '0;
            launch_top_q <= 1'b0;
            launch_bot_q <= 1'b0;
            chal_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_ARM;
          end
        end
        ST_ARM: begin
          launch_top_q <= 1'b0;
          launch_bot_q <= 1'b0;
          if (cnt_q == SETTLE_LAST) begin
            cnt_q        <= '0;
            launch_top_q <= 1'b1;
            launch_bot_q <= ~tm_q;
            state_q      <= ST_LAUNCH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SAMPLE: begin
          if (cnt_q == SAMPLE_LAST) begin
            cnt_q        <= '0;
            ones_q       <= ones_d;
            vote_q       <= vote_d;
            launch_top_q <= 1'b0;
            launch_bot_q <= 1'b0;
            if (vote_d < VOTES_MAX) begin
              state_q <= ST_ARM;
            end else begin
              resp_valid_q <= 1'b1;
              resp_q       <= (ones_d > VOTES_HALF);
              resp_conf_q  <= ones_d;
              state_q      <= ST_DONE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_q       <= 1'b0;
            resp_conf_q  <= '0;
            chal_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign chal_ready = chal_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp       = resp_q;
  assign resp_conf  = resp_conf_q;
  assign busy       = busy_q;

endmodule

// File: doc/puf_arbiter_chain.md
PUF_ARBITER_CHAIN -- requirements
Module: puf_arbiter_chain

Interface
REQ-001 SHALL have parameter N_STAGES, default 64, the number of crossing switch stages and the challenge width (legal range 1..256).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 8, the number of clock cycles for each discharge and settle window (legal minimum 2).
REQ-003 SHALL have parameter N_VOTES, default 5, the number of repeated evaluations per challenge (odd, at least 1).
REQ-004 SHALL have parameter VW, derived as $clog2(N_VOTES+1), the width of the vote count.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 SHALL have port chal_valid, input, 1 bit, challenge offered.
REQ-008 SHALL have port chal_ready, output, 1 bit, block can accept a challenge.
REQ-009 SHALL have port chal, input, N_STAGES bits, challenge; bit i drives stage i, with stage 0 nearest the launch point.
REQ-010 SHALL have port test_mode, input, 1 bit, deterministic-path mode; sampled together with chal.
REQ-011 SHALL have port resp_valid, output, 1 bit, response available.
REQ-012 SHALL have port resp_ready, input, 1 bit, consumer accepts the response.
REQ-013 SHALL have port resp, output, 1 bit, majority-voted response.
REQ-014 SHALL have port resp_conf, output, VW bits, the number of evaluations that returned 1.
REQ-015 SHALL have port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-016 Each stage SHALL pass paths straight through when its challenge bit is 0: top_out=top_in, bot_out=bot_in.
REQ-017 Each stage SHALL cross paths when its challenge bit is 1: top_out=bot_in, bot_out=top_in.
REQ-018 The arbiter SHALL be an SR latch: set when the top chain output rises first, reset when the bottom chain output rises first.
REQ-019 On a simultaneous arrival (tie), the arbiter SHALL hold its cleared value 0.
REQ-020 FSM states SHALL be IDLE, ARM, LAUNCH, SETTLE, SAMPLE, DONE.
REQ-021 IDLE SHALL assert chal_ready=1; on chal_valid&&chal_ready it SHALL register chal and test_mode, clear the vote counters, and enter ARM.
REQ-022 ARM SHALL drive both launch inputs to 0 and clear the arbiter for SETTLE_CYCLES cycles, then enter LAUNCH.
REQ-023 LAUNCH SHALL last 1 cycle and drive the top launch input to 1.
REQ-024 In LAUNCH, the bottom launch input SHALL be driven to 1 when test_mode=0 and held at 0 when test_mode=1.
REQ-025 SETTLE SHALL hold the launch inputs for SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-026 SAMPLE SHALL take 2 cycles (two-flop synchroniser on the arbiter output), then add the synchronised bit to ones_cnt and increment vote_cnt.
REQ-027 After SAMPLE, the FSM SHALL enter ARM while vote_cnt<N_VOTES, otherwise DONE.
REQ-028 Each evaluation SHALL take exactly 2*SETTLE_CYCLES+3 cycles.
REQ-029 resp_valid SHALL rise N_VOTES*(2*SETTLE_CYCLES+3) cycles after the accept edge.
REQ-030 DONE SHALL assert resp_valid, with resp=(ones_cnt>N_VOTES/2) and resp_conf=ones_cnt.
REQ-031 resp and resp_conf SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-032 On resp_valid&&resp_ready the FSM SHALL return to IDLE, and chal_ready SHALL be 1 on the following cycle.
REQ-033 chal_ready SHALL be 0 in every state except IDLE; chal_valid outside IDLE SHALL be ignored, with no queuing.
REQ-034 Changes on chal or test_mode after the accept edge SHALL NOT affect the evaluation in progress.
REQ-035 With test_mode=1, every evaluation SHALL return ~^chal_reg (1 when the challenge has an even number of ones), so resp_conf is 0 or N_VOTES.
REQ-036 ones_cnt and vote_cnt SHALL saturate at N_VOTES and SHALL never wrap.

Reset
REQ-037 While rst_n=0, the following SHALL be forced: FSM=IDLE, chal_ready=0, resp_valid=0, resp=0, resp_conf=0, busy=0.
REQ-038 While rst_n=0, counters, synchroniser flops, both launch inputs and the arbiter SHALL be forced to 0.
REQ-039 Reset assertion mid-evaluation SHALL abort immediately with no response emitted.
REQ-040 chal_ready SHALL go to 1 on the first clk edge after rst_n deasserts.

Structure
REQ-041 Shared package puf_pkg SHALL hold the FSM state enum and the vote-width helper function.
REQ-042 The stage SHALL be sub-module puf_switch_stage (two crossing 2:1 muxes, outputs kept through synthesis), instantiated N_STAGES times by generate.
REQ-043 Elaboration SHALL fail for an even N_VOTES, N_STAGES<1 or SETTLE_CYCLES<2.

Verification
REQ-044 Reset check: after reset, a 1-cycle pulse mid-SETTLE -> all outputs 0 during reset, chal_ready=1 on the first edge after release, no resp_valid.
REQ-045 Even-parity check: defaults, test_mode=1, chal=64'h0 -> resp_valid exactly 95 cycles after accept, resp=1, resp_conf=5.
REQ-046 Odd-parity check: test_mode=1, chal=64'h1 -> resp=0, resp_conf=0; chal=64'h3 -> resp=1, resp_conf=5.
REQ-047 Back-pressure check: hold resp_ready=0 for 20 cycles in DONE -> resp and resp_conf stable, chal_ready=0, a second chal_valid is ignored.
REQ-048 Capture check: change chal at accept+1 (test_mode=1, 64'h0 -> 64'h1) -> result matches 64'h0 (resp=1).
REQ-049 Tie check: test_mode=0 in zero-delay simulation -> every evaluation ties, so resp=0 and resp_conf=0 after 95 cycles.
